fb_scanout: RTL

FB_SCANOUT -- requirements
Module: fb_scanout

---
 rtl/fb_pkg.sv | 22 ++
 rtl/fb_scanout_if.sv | 12 +
 rtl/fb_lookahead_counter.sv | 43 ++++
 rtl/fb_scanout.sv | 126 ++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer constants and types for scanout, framebuffer and spi_gpu.
package fb_pkg;
  localparam int FB_WIDTH_DEF    = 320;
  localparam int FB_HEIGHT_DEF   = 240;
  localparam int SCALE_DEF       = 4;
  localparam int SCANOUT_LATENCY = 3;
  localparam int COORD_W         = 12;
  localparam int FB_ADDR_W       = 17;
  localparam int PAL_IDX_W       = 8;
  localparam int RGB_W           = 24;

  typedef logic [COORD_W-1:0]   coord_t;
  typedef logic [FB_ADDR_W-1:0] fb_addr_t;
  typedef logic [PAL_IDX_W-1:0] pal_idx_t;
  typedef logic [RGB_W-1:0]     rgb_t;

  // In-image test result for one pixel, carried down the read pipeline.
  typedef struct packed {
    logic in_x;
    logic in_y;
  } span_t;
endpackage

// File: rtl/fb_scanout_if.sv
// Read bus between the scanout engine and the index RAM / palette memories.
interface fb_scanout_if;
  import fb_pkg::*;

  fb_addr_t fb_addr;
  pal_idx_t fb_index;
  pal_idx_t pal_addr;
  rgb_t     pal_rgb;

  modport master (output fb_addr, output pal_addr, input fb_index, input pal_rgb);
  modport slave  (input fb_addr, input pal_addr, output fb_index, output pal_rgb);
endinterface

// File: rtl/fb_lookahead_counter.sv
// Raster position running SCANOUT_LATENCY pixels ahead of cx/cy, resynced at (0,0).
module fb_lookahead_counter
  import fb_pkg::*;
(
  input  logic   clk_pixel,
  input  logic   reset,
  input  coord_t cx,
  input  coord_t cy,
  input  coord_t frame_width,
  input  coord_t frame_height,
  output coord_t lx,
  output coord_t ly,
  output coord_t lx_nxt,
  output coord_t ly_nxt
);
  localparam coord_t LX_START = coord_t'(SCANOUT_LATENCY);

  coord_t lx_q, ly_q;
  logic   sync;

  // The resync value applies to the current cycle so the look-ahead is exact at cx=0,cy=0.
  always_comb begin
    sync   = (cx == '0) && (cy == '0);
    lx     = sync ? LX_START : lx_q;
    ly     = sync ? '0 : ly_q;
    lx_nxt = lx + 12'd1;
    ly_nxt = ly;
    if (lx >= frame_width - 12'd1) begin
      lx_nxt = '0;
      ly_nxt = (ly >= frame_height - 12'd1) ? '0 : ly + 12'd1;
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      lx_q <= LX_START;
      ly_q <= '0;
    end else begin
      lx_q <= lx_nxt;
      ly_q <= ly_nxt;
    end
  end
endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scanout: look-ahead addressing, index RAM and palette pipeline to HDMI pixels.
// Define FB_SCANOUT_BORDER_EN to show palette entry 0 outside the image instead of black.
module fb_scanout
  import fb_pkg::*;
#(
  parameter int FB_WIDTH  = FB_WIDTH_DEF,
  parameter int FB_HEIGHT = FB_HEIGHT_DEF,
  parameter int SCALE     = SCALE_DEF,
  parameter int OFFSET_X  = 320,
  parameter int OFFSET_Y  = 60
) (
  input  logic         clk_pixel,
  input  logic         reset,
  input  coord_t       cx,
  input  coord_t       cy,
  input  coord_t       frame_width,
  input  coord_t       frame_height,
  fb_scanout_if.master mem,
  output rgb_t         rgb,
  output logic         hblank,
  output logic         vblank
);
  localparam coord_t   X_LO     = coord_t'(OFFSET_X);
  localparam coord_t   X_HI     = coord_t'(OFFSET_X + FB_WIDTH * SCALE);
  localparam coord_t   Y_LO     = coord_t'(OFFSET_Y);
  localparam coord_t   Y_HI     = coord_t'(OFFSET_Y + FB_HEIGHT * SCALE);
  localparam fb_addr_t ROW_STEP = fb_addr_t'(FB_WIDTH);
  localparam int       SC_W     = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCALE - 1);

  coord_t lx, ly, lx_nxt, ly_nxt;
  logic   in_x, in_y, in_x_n, in_y_n, line_step;
  logic [SC_W-1:0] sx, sy, sx_n, sy_n;
  fb_addr_t col, row_base, col_n, row_base_n;
  span_t  span1, span2;

  fb_lookahead_counter u_lookahead (
    .clk_pixel    (clk_pixel),
    .reset        (reset),
    .cx           (cx),
    .cy           (cy),
    .frame_width  (frame_width),
    .frame_height (frame_height),
    .lx           (lx),
    .ly           (ly),
    .lx_nxt       (lx_nxt),
    .ly_nxt       (ly_nxt)
  );

  // col/row_base describe the current look-ahead pixel; the *_n values describe the next one,
  // so fb_addr can be registered in step with lx/ly.
  always_comb begin
    in_x      = (lx >= X_LO) && (lx < X_HI);
    in_y      = (ly >= Y_LO) && (ly < Y_HI);
    in_x_n    = (lx_nxt >= X_LO) && (lx_nxt < X_HI);
    in_y_n    = (ly_nxt >= Y_LO) && (ly_nxt < Y_HI);
    line_step = (ly_nxt != ly);

    sx_n  = '0;
    col_n = '0;
    if (in_x && in_x_n) begin
      if (sx == SC_LAST) begin
        col_n = col + fb_addr_t'(1);
      end else begin
        sx_n  = sx + SC_W'(1);
        col_n = col;
      end
    end

    sy_n       = '0;
    row_base_n = '0;
    if (in_y && in_y_n) begin
      if (!line_step) begin
        sy_n       = sy;
        row_base_n = row_base;
      end else if (sy == SC_LAST) begin
        row_base_n = row_base + ROW_STEP;
      end else begin
        sy_n       = sy + SC_W'(1);
        row_base_n = row_base;
      end
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      sx          <= '0;
      sy          <= '0;
      col         <= '0;
      row_base    <= '0;
      mem.fb_addr <= '0;
      span1       <= '0;
      span2       <= '0;
    end else begin
      sx       <= sx_n;
      sy       <= sy_n;
      col      <= col_n;
      row_base <= row_base_n;
      if (in_x_n && in_y_n) begin
        mem.fb_addr <= row_base_n + col_n;
      end
      span1 <= '{in_x: in_x, in_y: in_y};
      span2 <= span1;
    end
  end

  always_comb begin
    mem.pal_addr = (span1.in_x && span1.in_y) ? mem.fb_index : '0;
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      rgb    <= '0;
      hblank <= 1'b1;
      vblank <= 1'b1;
    end else begin
      hblank <= !span2.in_x;
      vblank <= !span2.in_y;
`ifdef FB_SCANOUT_BORDER_EN
      rgb    <= mem.pal_rgb;
`else
      rgb    <= (span2.in_x && span2.in_y) ? mem.pal_rgb : '0;
`endif
    end
  end
endmodule
